// File: rtl/csa_add_sched.sv
// Two-requester word-serial add/subtract scheduler in front of a shared 32-bit
// carry-select adder; the grant is locked per transaction and the result is registered.
module csa_add_sched (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req0_sub,
  input  logic        req0_last,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic        req1_sub,
  input  logic        req1_last,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  output logic        add_cin,
  input  logic [31:0] add_sum,
  input  logic        add_cout,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_sum,
  output logic        res_cout,
  output logic        res_ovf,
  output logic        res_id,
  output logic        res_last
);

  typedef enum logic [1:0] {ST_IDLE, ST_OWN0, ST_OWN1} state_t;

  state_t      r_state;
  logic        r_rr_ptr;
  logic        r_carry;
  logic        r_sub;
  logic        r_res_valid;
  logic [31:0] r_res_sum;
  logic        r_res_cout;
  logic        r_res_ovf;
  logic        r_res_id;
  logic        r_res_last;

  logic        w_gnt;
  logic        w_gnt_valid;
  logic        w_first;
  logic [31:0] w_a;
  logic [31:0] w_b;
  logic        w_gnt_sub;
  logic        w_last;
  logic        w_sub;
  logic [31:0] w_b_post;
  logic        w_cin;
  logic        w_accept;
  logic        w_ovf;

  // NOTE: every variable assigned here gets a default first so no latch is inferred.
  always_comb begin
    w_gnt       = 1'b0;
    w_gnt_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_gnt       = (req0_valid && req1_valid) ? r_rr_ptr : req1_valid;
        w_gnt_valid = req0_valid | req1_valid;
      end
      ST_OWN0: begin
        w_gnt       = 1'b0;
        w_gnt_valid = req0_valid;
      end
      ST_OWN1: begin
        w_gnt       = 1'b1;
        w_gnt_valid = req1_valid;
      end
      default: begin
        w_gnt       = 1'b0;
        w_gnt_valid = 1'b0;
      end
    endcase
  end

  assign w_first   = (r_state == ST_IDLE);
  assign w_a       = w_gnt ? req1_a    : req0_a;
  assign w_b       = w_gnt ? req1_b    : req0_b;
  assign w_gnt_sub = w_gnt ? req1_sub  : req0_sub;
  assign w_last    = w_gnt ? req1_last : req0_last;
  // The subtract mode is only sampled on the first beat; later beats use the latched copy.
  assign w_sub     = w_first ? w_gnt_sub : r_sub;
  assign w_b_post  = w_sub ? ~w_b : w_b;
  assign w_cin     = w_first ? w_gnt_sub : r_carry;
  assign w_accept  = rst_n & w_gnt_valid & (~r_res_valid | res_ready);
  assign w_ovf     = w_last & (w_a[31] == w_b_post[31]) & (add_sum[31] != w_a[31]);

  // Combinational outputs are gated by rst_n so the whole interface reads 0 during reset.
  assign req0_ready = w_accept & ~w_gnt;
  assign req1_ready = w_accept &  w_gnt;
  assign add_a      = rst_n ? w_a      : 32'd0;
  assign add_b      = rst_n ? w_b_post : 32'd0;
  assign add_cin    = rst_n & w_cin;

  assign res_valid = r_res_valid;
  assign res_sum   = r_res_sum;
  assign res_cout  = r_res_cout;
  assign res_ovf   = r_res_ovf;
  assign res_id    = r_res_id;
  assign res_last  = r_res_last;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= 1'b0;
      r_carry     <= 1'b0;
      r_sub       <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_sum   <= 32'd0;
      r_res_cout  <= 1'b0;
      r_res_ovf   <= 1'b0;
      r_res_id    <= 1'b0;
      r_res_last  <= 1'b0;
    end else if (w_accept) begin
      r_res_valid <= 1'b1;
      r_res_sum   <= add_sum;
      r_res_cout  <= add_cout;
      r_res_ovf   <= w_ovf;
      r_res_id    <= w_gnt;
      r_res_last  <= w_last;
      if (w_first) r_sub <= w_gnt_sub;
      if (w_last) begin
        r_state  <= ST_IDLE;
        r_carry  <= 1'b0;
        r_rr_ptr <= ~w_gnt;
      end else begin
        r_state  <= w_gnt ? ST_OWN1 : ST_OWN0;
        r_carry  <= add_cout;
      end
    end else if (res_ready) begin
      r_res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_csa_add_sched.sv
// Directed bench for csa_add_sched; the shared carry-select adder is modelled
// here as an ideal 32-bit adder driven by the DUT's add_* outputs.
module tb_csa_add_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req0_sub, req0_last;
  logic [31:0] req0_a, req0_b;
  logic        req1_valid, req1_ready, req1_sub, req1_last;
  logic [31:0] req1_a, req1_b;
  logic [31:0] add_a, add_b, add_sum;
  logic        add_cin, add_cout;
  logic        res_valid, res_ready, res_cout, res_ovf, res_id, res_last;
  logic [31:0] res_sum;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};

  csa_add_sched dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_sub(req0_sub), .req0_last(req0_last),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_sub(req1_sub), .req1_last(req1_last),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout),
    .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum), .res_cout(res_cout),
    .res_ovf(res_ovf), .res_id(res_id), .res_last(res_last)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv0(input logic v, input logic [31:0] a, input logic [31:0] b,
                      input logic sub, input logic last);
    req0_valid = v; req0_a = a; req0_b = b; req0_sub = sub; req0_last = last;
    #1;
  endtask

  task automatic drv1(input logic v, input logic [31:0] a, input logic [31:0] b,
                      input logic sub, input logic last);
    req1_valid = v; req1_a = a; req1_b = b; req1_sub = sub; req1_last = last;
    #1;
  endtask

  task automatic check_res(input string tag, input logic [31:0] sum, input logic cout,
                           input logic ovf, input logic id, input logic last);
    check({tag, "_valid"}, {31'd0, res_valid}, 32'd1);
    check({tag, "_sum"},   res_sum,            sum);
    check({tag, "_cout"},  {31'd0, res_cout},  {31'd0, cout});
    check({tag, "_ovf"},   {31'd0, res_ovf},   {31'd0, ovf});
    check({tag, "_id"},    {31'd0, res_id},    {31'd0, id});
    check({tag, "_last"},  {31'd0, res_last},  {31'd0, last});
  endtask

  initial begin
    rst_n = 1'b0;
    res_ready = 1'b1;
    drv0(1'b1, 32'h1234_5678, 32'h0000_0001, 1'b1, 1'b1);
    drv1(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    tick();
    // Outputs during reset, with a requester actively offering a beat.
    check("rst_res_valid", {31'd0, res_valid}, 32'd0);
    check("rst_res_sum",   res_sum,            32'd0);
    check("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
    check("rst_add_a",     add_a,              32'd0);
    check("rst_add_b",     add_b,              32'd0);
    check("rst_add_cin",   {31'd0, add_cin},   32'd0);
    drv0(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();

    // 2-word add on req0: {1,FFFFFFFF} + {0,1}.
    drv0(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    check("add2_w0_ready", {31'd0, req0_ready}, 32'd1);
    check("add2_w0_cin",   {31'd0, add_cin},    32'd0);
    tick();
    check_res("add2_w0", 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0);
    drv0(1'b1, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b1);
    check("add2_w1_cin", {31'd0, add_cin}, 32'd1);
    tick();
    check_res("add2_w1", 32'h0000_0002, 1'b0, 1'b0, 1'b0, 1'b1);

    // Single-beat subtract on req1: 5 - 7.
    drv0(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    drv1(1'b1, 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1);
    check("sub_ready", {31'd0, req1_ready}, 32'd1);
    check("sub_cin",   {31'd0, add_cin},    32'd1);
    check("sub_add_b", add_b,               32'hFFFF_FFF8);
    tick();
    check_res("sub", 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1, 1'b1);

    // Signed overflow: 7FFFFFFF + 1.
    drv1(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    drv0(1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
    tick();
    check_res("ovf", 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1);

    // Fresh reset so rr_ptr=0, then both requesters contend with 1-beat adds.
    drv0(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    drv0(1'b1, 32'h0000_0010, 32'h0000_0001, 1'b0, 1'b1);
    drv1(1'b1, 32'h0000_0020, 32'h0000_0002, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rr%0d_ready0", i), {31'd0, req0_ready}, {31'd0, (i % 2) == 0});
      check($sformatf("rr%0d_ready1", i), {31'd0, req1_ready}, {31'd0, (i % 2) == 1});
      tick();
      check($sformatf("rr%0d_id", i),  {31'd0, res_id}, {31'd0, (i % 2) == 1});
      check($sformatf("rr%0d_sum", i), res_sum, ((i % 2) == 1) ? 32'h0000_0022 : 32'h0000_0011);
      #1;
    end
    drv0(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    drv1(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    tick();
    check("drain_valid", {31'd0, res_valid}, 32'd0);

    // 3-word add with a 3-cycle consumer stall and an owner gap.
    drv0(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    tick();
    check_res("stl_w0", 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0);
    res_ready = 1'b0;
    drv0(1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0);
    drv1(1'b1, 32'h0000_0009, 32'h0000_0009, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("stl%0d_ready0", i), {31'd0, req0_ready}, 32'd0);
      check($sformatf("stl%0d_ready1", i), {31'd0, req1_ready}, 32'd0);
      tick();
      check_res($sformatf("stl%0d_hold", i), 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    res_ready = 1'b1;
    #1;
    check("stl_w1_ready0", {31'd0, req0_ready}, 32'd1);
    check("stl_w1_ready1", {31'd0, req1_ready}, 32'd0);
    check("stl_w1_cin",    {31'd0, add_cin},    32'd1);
    tick();
    check_res("stl_w1", 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0);
    drv0(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    check("gap_ready0", {31'd0, req0_ready}, 32'd0);
    check("gap_ready1", {31'd0, req1_ready}, 32'd0);
    tick();
    check("gap_valid", {31'd0, res_valid}, 32'd0);
    drv0(1'b1, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1);
    check("stl_w2_cin",   {31'd0, add_cin}, 32'd1);
    check("stl_w2_add_b", add_b,            32'h0000_0000);
    tick();
    check_res("stl_w2", 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b1);

    // req1 was waiting and now wins in IDLE.
    drv0(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    check("post_ready1", {31'd0, req1_ready}, 32'd1);
    tick();
    check_res("post", 32'h0000_0012, 1'b0, 1'b0, 1'b1, 1'b1);
    drv1(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    tick();

    // Reset after the first word of a 2-word add leaves no stale carry.
    drv0(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    tick();
    check_res("mid_w0", 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid",  {31'd0, res_valid},  32'd0);
    check("mid_rst_sum",    res_sum,             32'd0);
    check("mid_rst_cout",   {31'd0, res_cout},   32'd0);
    check("mid_rst_ready0", {31'd0, req0_ready}, 32'd0);
    check("mid_rst_add_a",  add_a,               32'd0);
    rst_n = 1'b1;
    drv0(1'b1, 32'h0000_0003, 32'h0000_0004, 1'b0, 1'b1);
    check("new_cin",    {31'd0, add_cin},    32'd0);
    check("new_ready0", {31'd0, req0_ready}, 32'd1);
    tick();
    check_res("new", 32'h0000_0007, 1'b0, 1'b0, 1'b0, 1'b1);
    drv0(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
